glyph_line_prefetch: RTL and testbench



---
 rtl/glyph_line_prefetch.sv | 137 +++++++++++++
 tb/tb_glyph_line_prefetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_line_prefetch.sv
// Font ROM scheduler: fetches one glyph row per cell during hblank
// into a double-buffered line buffer read by the pixel path.
module glyph_line_prefetch #(
  parameter int NCELLS  = 16,
  parameter int ROM_LAT = 1,
  localparam int CW = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
  input  logic          SCLKclk,
  input  logic          rst,
  input  logic          line_start,
  output logic [CW-1:0] cell_idx,
  input  logic [6:0]    char_code,
  input  logic [4:0]    row_sel,
  input  logic          cell_en,
  output logic [11:0]   rom_addr,
  input  logic [15:0]   rom_data,
  input  logic [3:0]    rd_cell,
  input  logic [3:0]    rd_bit,
  output logic          pix_bit,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  input  logic          clr_ovr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int PD = ROM_LAT + 1;
  localparam logic [ROM_LAT:0] TOP = (ROM_LAT + 1)'(1) << ROM_LAT;

  logic [1:0]    state;
  logic          fsel;
  logic [15:0]   bank [2][NCELLS];
  logic [ROM_LAT:0] pv;
  logic [ROM_LAT:0] pe;
  logic [CW-1:0] pc [PD];

  logic accept;
  logic last_cell;
  logic drain_end;
  logic in_range;

  assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign accept    = line_start && !busy;
  assign last_cell = (cell_idx == CW'(NCELLS - 1));
  // only the final stage may still be occupied on the last drain cycle
  assign drain_end = ~|(pv & ~TOP);
  assign in_range  = 32'(rd_cell) < NCELLS;

  always_ff @(posedge SCLKclk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      fsel     <= 1'b0;
      cell_idx <= '0;
      rom_addr <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            fsel     <= ~fsel;
            cell_idx <= '0;
            state    <= S_ISSUE;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          rom_addr <= {char_code, row_sel};
          if (last_cell) begin
            cell_idx <= '0;
            state    <= S_DRAIN;
          end else begin
            cell_idx <= cell_idx + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_end) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge SCLKclk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      pe <= '0;
      for (int i = 0; i < PD; i++) pc[i] <= '0;
    end else begin
      pv[0] <= (state == S_ISSUE);
      pe[0] <= cell_en;
      pc[0] <= cell_idx;
      for (int i = 1; i < PD; i++) begin
        pv[i] <= pv[i-1];
        pe[i] <= pe[i-1];
        pc[i] <= pc[i-1];
      end
    end
  end

  always_ff @(posedge SCLKclk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < NCELLS; c++)
          bank[b][c] <= 16'h0000;
    end else if (pv[ROM_LAT]) begin
      bank[~fsel][pc[ROM_LAT]] <=
        pe[ROM_LAT] ? rom_data : 16'h0000;
    end
  end

  always_ff @(posedge SCLKclk or posedge rst) begin
    if (rst) begin
      pix_bit <= 1'b0;
    end else if (in_range) begin
      pix_bit <= bank[fsel][rd_cell[CW-1:0]][~rd_bit];
    end else begin
      pix_bit <= 1'b0;
    end
  end

  // a busy-time request wins over a simultaneous clear
  always_ff @(posedge SCLKclk or posedge rst) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (line_start && busy) begin
      overrun <= 1'b1;
    end else if (clr_ovr) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_glyph_line_prefetch.sv
// Randomized bench for glyph_line_prefetch against a cycle-level
// line/bank model derived from the fetch timing rules.
module tb_glyph_line_prefetch;

  localparam int NC   = 16;
  localparam int LAT  = 1;
  localparam int BEND = NC + LAT + 1;
  localparam int DOFS = NC + LAT + 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [3:0]  cell_idx;
  logic [6:0]  char_code;
  logic [4:0]  row_sel;
  logic        cell_en;
  logic [11:0] rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  rd_cell;
  logic [3:0]  rd_bit;
  logic        pix_bit;
  logic        busy;
  logic        done;
  logic        overrun;
  logic        clr_ovr;

  logic [6:0] chars [NC];
  logic [4:0] rows  [NC];
  logic       ens   [NC];
  bit rom_mode;
  bit rnd_rd;

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;

  glyph_line_prefetch #(.NCELLS(NC), .ROM_LAT(LAT)) dut (
    .SCLKclk(clk), .rst(rst), .line_start(line_start),
    .cell_idx(cell_idx), .char_code(char_code), .row_sel(row_sel),
    .cell_en(cell_en), .rom_addr(rom_addr), .rom_data(rom_data),
    .rd_cell(rd_cell), .rd_bit(rd_bit), .pix_bit(pix_bit),
    .busy(busy), .done(done), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  assign char_code = chars[cell_idx];
  assign row_sel   = rows[cell_idx];
  assign cell_en   = ens[cell_idx];

  function automatic logic [15:0] romfn(logic [11:0] a, bit m);
    if (m) return 16'hFFFF;
    return (16'(a) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge clk) rom_data <= romfn(rom_addr, rom_mode);
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, a, e, cyc);
  endtask

  // model: accepted fetch start T, completed lines per bank
  bit          act;
  int          T;
  bit          mf;
  logic [15:0] mb [2][NC];
  logic [15:0] nl [NC];
  logic [11:0] na [NC];
  logic        e_pix;
  logic [11:0] e_addr;
  logic        e_ovr;

  always @(negedge clk) begin : model
    int k;
    bit eb;
    if (rst) begin
      act = 0; mf = 0; e_pix = 0; e_addr = 0; e_ovr = 0;
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < NC; c++) mb[b][c] = 16'h0;
    end else begin
      eb = act && cyc >= T + 1 && cyc <= T + BEND;
      chk("busy", busy, eb);
      chk("done", done, act && cyc == T + DOFS);
      chk("rom_addr", rom_addr, e_addr);
      chk("pix_bit", pix_bit, e_pix);
      chk("overrun", overrun, e_ovr);
      k = cyc - T - 1;
      if (act && k >= 0 && k < NC) begin
        chk("cell_idx", cell_idx, k);
        e_addr = na[k];
      end
      e_pix = mb[mf][rd_cell][4'd15 - rd_bit];
      if (line_start && eb) e_ovr = 1;
      else if (clr_ovr) e_ovr = 0;
      if (act && cyc == T + DOFS) begin
        for (int c = 0; c < NC; c++) mb[!mf][c] = nl[c];
        act = 0;
      end
      if (line_start && !eb) begin
        mf = !mf; act = 1; T = cyc;
        for (int c = 0; c < NC; c++) begin
          na[c] = {chars[c], rows[c]};
          nl[c] = ens[c] ? romfn(na[c], rom_mode) : 16'h0;
        end
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (rnd_rd) begin
      rd_cell = 4'($urandom);
      rd_bit  = 4'($urandom);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pulse_ls;
    line_start = 1'b1; tick; line_start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int expn);
    int n;
    n = n0;
    while (!done && n < 60) begin tick; n++; end
    chk("done_cycle", n, expn);
  endtask

  task automatic sweep;
    rnd_rd = 0;
    for (int c = 0; c < NC; c++)
      for (int b = 0; b < 16; b++) begin
        rd_cell = 4'(c); rd_bit = 4'(b); tick;
      end
  endtask

  task automatic rand_line(input bit all_en);
    for (int c = 0; c < NC; c++) begin
      chars[c] = 7'($urandom);
      rows[c]  = 5'($urandom);
      ens[c]   = all_en ? 1'b1 : ($urandom % 4 != 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1; line_start = 0; clr_ovr = 0;
    rd_cell = 0; rd_bit = 0; rnd_rd = 0; rom_mode = 0;
    for (int c = 0; c < NC; c++) begin
      chars[c] = 7'h30 + 7'(c); rows[c] = 5'd3; ens[c] = 1'b1;
    end
    repeat (3) tick;
    rst = 0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_pix", pix_bit, 0);
    sweep;

    pulse_ls;
    chk("busy_T1", busy, 1);
    tick;
    chk("addr_T2", rom_addr, 12'h603);
    wait_done(2, 19);
    chk("busy_at_done", busy, 0);

    line_start = 1; tick; line_start = 0;
    rd_cell = 4'd2; rd_bit = 4'd0; tick;
    chk("pix_c2_b0", pix_bit, romfn(12'h643, 0) >> 15);
    wait_done(2, 19);

    rom_mode = 1;
    for (int c = 0; c < NC; c++) begin
      chars[c] = 7'($urandom); rows[c] = 5'($urandom);
      ens[c] = !(c >= 4 && c <= 7);
    end
    pulse_ls;
    wait_done(1, 19);
    rom_mode = 0;
    rand_line(1);
    pulse_ls;
    rd_cell = 4'd5; rd_bit = 4'd0; tick;
    chk("blank_c5", pix_bit, 0);
    rd_cell = 4'd9; rd_bit = 4'd7; tick;
    chk("full_c9", pix_bit, 1);
    sweep;

    rand_line(0);
    pulse_ls;
    repeat (9) tick;
    pulse_ls;
    chk("ovr_set", overrun, 1);
    wait_done(11, 19);
    chk("ovr_held", overrun, 1);

    pulse_ls;
    repeat (3) tick;
    line_start = 1; clr_ovr = 1; tick;
    line_start = 0; clr_ovr = 0;
    chk("ovr_set_wins", overrun, 1);
    wait_done(5, 19);
    clr_ovr = 1; tick; clr_ovr = 0;
    chk("ovr_clr", overrun, 0);

    repeat (6) begin
      rand_line(0);
      pulse_ls;
      rnd_rd = 1;
      repeat (22) begin
        line_start = ($urandom % 12 == 0);
        clr_ovr    = ($urandom % 9 == 0);
        tick;
      end
      line_start = 0; clr_ovr = 0;
      n = 0;
      while ((busy || done) && n < 60) begin tick; n++; end
      chk("idle_wait", n < 60, 1);
    end
    rnd_rd = 0;

    rand_line(0);
    pulse_ls;
    repeat (2) tick;
    pulse_ls;
    chk("ovr_pre_rst", overrun, 1);
    repeat (4) tick;
    #1 rst = 1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_ovr", overrun, 0);
    chk("arst_done", done, 0);
    chk("arst_pix", pix_bit, 0);
    @(posedge clk); #1 rst = 0;
    sweep;
    rand_line(0);
    pulse_ls;
    chk("post_rst_busy", busy, 1);
    rd_cell = 4'd3; rd_bit = 4'd4; tick;
    chk("bank1_zero", pix_bit, 0);
    wait_done(2, 19);
    rand_line(1);
    pulse_ls;
    sweep;

    repeat (2) tick;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
